// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up-counter between two requesters: grants a
// winner, clears the counter, enables it for the latched tick count, then pulses done.
module counter_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic [WIDTH-1:0] cnt_value,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             cnt_reset,
  output logic             cnt_enable
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_last;
  logic [WIDTH-1:0] r_len;

  logic             w_winner;
  logic [WIDTH-1:0] w_last_tick;
  logic [1:0]       w_owner_oh;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_winner = ~r_last;
    if (req == 2'b01) begin
      w_winner = 1'b0;
    end else if (req == 2'b10) begin
      w_winner = 1'b1;
    end
  end

  // A zero length wraps to all ones, giving a full 2^WIDTH-tick run.
  assign w_last_tick = r_len - WIDTH'(1);
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_len   <= w_winner ? len1 : len0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: r_state <= S_RUN;
        S_RUN: begin
          if (cnt_value == w_last_tick) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = (r_state == S_CLEAR || r_state == S_RUN) ? w_owner_oh : 2'b00;
  assign done       = (r_state == S_DONE) ? w_owner_oh : 2'b00;
  assign busy       = (r_state != S_IDLE);
  assign cnt_reset  = (r_state == S_CLEAR);
  assign cnt_enable = (r_state == S_RUN);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural 4-bit counter and a
// queue of expected jobs (owner, length) pushed when requests are driven.
module tb_counter_arbiter;

  typedef struct {
    logic       owner;
    logic [3:0] len;
  } job_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [3:0] cnt = 4'd0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       cnt_reset;
  logic       cnt_enable;

  job_t exp_q[$];
  logic m_last = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  counter_arbiter #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req        (req),
    .len0       (len0),
    .len1       (len1),
    .cnt_value  (cnt),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .cnt_reset  (cnt_reset),
    .cnt_enable (cnt_enable)
  );

  always #5 clk = ~clk;

  // The shared counter: synchronous clear, enable, not touched by the arbiter reset.
  always @(posedge clk) begin
    if (cnt_reset) cnt <= 4'd0;
    else if (cnt_enable) cnt <= cnt + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_not_multihot", 32'($countones(gnt) <= 1), 1);
    check("reset_enable_exclusive", 32'(cnt_reset & cnt_enable), 0);
  endtask

  task automatic push_job(input logic [1:0] r);
    job_t j;
    if (r == 2'b01) j.owner = 1'b0;
    else if (r == 2'b10) j.owner = 1'b1;
    else j.owner = ~m_last;
    m_last = j.owner;
    j.len  = j.owner ? len1 : len0;
    exp_q.push_back(j);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_seen", 32'(ok), 1);
  endtask

  task automatic run_job(input logic [1:0] req_after, input bit withdraw);
    job_t       e;
    bit         ok;
    int         n_en;
    logic [1:0] oh;
    wait_grant(ok);
    if (!ok) return;
    check("queue_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    oh = e.owner ? 2'b10 : 2'b01;
    check("gnt_at_grant", 32'(gnt), 32'(oh));
    check("cnt_reset_clear", 32'(cnt_reset), 1);
    check("busy_clear", 32'(busy), 1);
    tick();
    if (withdraw) begin
      req  = 2'b00;
      len0 = 4'd9;
    end
    n_en = 0;
    while (cnt_enable && n_en < 40) begin
      check("cnt_step", 32'(cnt), 32'(n_en[3:0]));
      check("gnt_run", 32'(gnt), 32'(oh));
      n_en++;
      tick();
    end
    check("run_length", 32'(n_en), (e.len == 4'd0) ? 32'd16 : 32'(e.len));
    check("done_pulse", 32'(done), 32'(oh));
    check("gnt_done", 32'(gnt), 0);
    check("busy_done", 32'(busy), 1);
    check("cnt_final", 32'(cnt), 32'(e.len));
    req = req_after;
    tick();
    check("done_cleared", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  task automatic reset_pulse();
    rst_n  = 1'b0;
    m_last = 1'b1;
    #1;
    check("reset_outputs", 32'({gnt, done, busy, cnt_reset, cnt_enable}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    req   = 2'b01;
    len0  = 4'd3;
    len1  = 4'd0;
    tick();
    check("reset_state", 32'({gnt, done, busy, cnt_reset, cnt_enable}), 0);

    // Single request released with reset.
    push_job(req);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(2'b00, 1'b0);

    // Tie from reset: requester 0 first, then hand-over after one IDLE cycle.
    reset_pulse();
    len0 = 4'd2;
    len1 = 4'd5;
    req  = 2'b11;
    push_job(req);
    push_job(req);
    run_job(2'b11, 1'b0);
    run_job(2'b00, 1'b0);

    // Fairness under continuous requests.
    len0 = 4'd1;
    len1 = 4'd1;
    req  = 2'b11;
    for (int k = 0; k < 6; k++) push_job(req);
    for (int k = 0; k < 6; k++) run_job((k == 5) ? 2'b00 : 2'b11, 1'b0);

    // Zero length runs the full wrap.
    len1 = 4'd0;
    req  = 2'b10;
    push_job(req);
    run_job(2'b00, 1'b0);

    // Reset in the middle of a run, then a fresh job.
    len0 = 4'd10;
    req  = 2'b01;
    push_job(req);
    wait_grant(ok);
    if (ok) void'(exp_q.pop_front());
    repeat (5) tick();
    check("run_before_reset", 32'(cnt_enable), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({gnt, done, busy, cnt_reset, cnt_enable}), 0);
    m_last = 1'b1;
    push_job(req);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(2'b00, 1'b0);

    // Request withdrawn and length changed after the grant.
    len0 = 4'd4;
    req  = 2'b01;
    push_job(req);
    run_job(2'b00, 1'b1);
    repeat (5) begin
      tick();
      check("stay_idle", 32'({gnt, busy}), 0);
    end
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
